// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU engine: FSM states, default width and
// the decode function codes IDU/EXU use to steer DIV/DIVU into this unit.
package div_unit_pkg;

  localparam int unsigned DivWidth = 32;

  // SPECIAL-opcode function fields for the two divide instructions
  localparam logic [5:0] FunctDiv  = 6'h1a;
  localparam logic [5:0] FunctDivu = 6'h1b;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivBusy = 2'd1,
    DivFix  = 2'd2,
    DivDone = 2'd3
  } divState_e;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle, fixed WIDTH+2 latency.
// Produces a single LO/HI write pulse in the same form EXU drives into HiLo.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] wLoData,
  output logic             wlo,
  output logic [WIDTH-1:0] wHiData,
  output logic             whi
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef struct packed {
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
  } divStep_t;

  // One restoring step: shift the next dividend bit into the partial remainder and
  // subtract the divisor only when that does not borrow.
  function automatic divStep_t divStep(input logic [WIDTH-1:0] rem,
                                       input logic [WIDTH-1:0] quo,
                                       input logic [WIDTH-1:0] dvs);
    divStep_t   res;
    logic [WIDTH:0] partial;
    logic [WIDTH:0] trial;
    partial = {rem, quo[WIDTH-1]};
    trial   = partial - {1'b0, dvs};
    res.rem = trial[WIDTH] ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
    res.quo = {quo[WIDTH-2:0], ~trial[WIDTH]};
    return res;
  endfunction

  divState_e        stateQ, stateD;
  logic [CntW-1:0]  cntQ, cntD;
  logic [WIDTH-1:0] remQ, remD;
  logic [WIDTH-1:0] quoQ, quoD;
  logic [WIDTH-1:0] dvsQ, dvsD;
  logic             qNegQ, qNegD;
  logic             rNegQ, rNegD;
  logic [WIDTH-1:0] loQ, loD;
  logic [WIDTH-1:0] hiQ, hiD;

  logic             aNeg, bNeg;
  logic [WIDTH-1:0] absA, absB;
  divStep_t         step;

  assign aNeg = signed_i & dividend[WIDTH-1];
  assign bNeg = signed_i & divisor[WIDTH-1];
  assign absA = aNeg ? -dividend : dividend;
  assign absB = bNeg ? -divisor  : divisor;
  assign step = divStep(remQ, quoQ, dvsQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= DivIdle;
      cntQ   <= '0;
      remQ   <= '0;
      quoQ   <= '0;
      dvsQ   <= '0;
      qNegQ  <= 1'b0;
      rNegQ  <= 1'b0;
      loQ    <= '0;
      hiQ    <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      remQ   <= remD;
      quoQ   <= quoD;
      dvsQ   <= dvsD;
      qNegQ  <= qNegD;
      rNegQ  <= rNegD;
      loQ    <= loD;
      hiQ    <= hiD;
    end
  end

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    remD   = remQ;
    quoD   = quoQ;
    dvsD   = dvsQ;
    qNegD  = qNegQ;
    rNegD  = rNegQ;
    loD    = loQ;
    hiD    = hiQ;
    stall  = 1'b0;
    done   = 1'b0;

    unique case (stateQ)
      DivIdle: begin
        // Stall is combinational on start so EXU freezes in the request cycle itself
        if (start && !cancel) begin
          stall  = 1'b1;
          stateD = DivBusy;
          cntD   = '0;
          remD   = '0;
          quoD   = absA;
          dvsD   = absB;
          qNegD  = aNeg ^ bNeg;
          rNegD  = aNeg;
        end
      end
      DivBusy: begin
        stall = 1'b1;
        remD  = step.rem;
        quoD  = step.quo;
        cntD  = cntQ + 1'b1;
        if (cntQ == LastCnt) begin
          stateD = DivFix;
        end
      end
      DivFix: begin
        stall  = 1'b1;
        stateD = DivDone;
        // A flushed divide leaves the previous result on the write buses
        if (!cancel) begin
          loD = qNegQ ? -quoQ : quoQ;
          hiD = rNegQ ? -remQ : remQ;
        end
      end
      DivDone: begin
        done   = !cancel;
        stateD = DivIdle;
      end
      default: stateD = DivIdle;
    endcase

    if (cancel) begin
      stateD = DivIdle;
    end
  end

  assign wLoData = loQ;
  assign wHiData = hiQ;
  assign wlo     = done;
  assign whi     = done;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, stall window, signed/unsigned results, divide by zero,
// cancel, reset mid-divide, ignored start and back-to-back requests.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_i;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        stall;
  logic        done;
  logic [31:0] wLoData;
  logic        wlo;
  logic [31:0] wHiData;
  logic        whi;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .signed_i (signed_i),
    .dividend (dividend),
    .divisor  (divisor),
    .cancel   (cancel),
    .stall    (stall),
    .done     (done),
    .wLoData  (wLoData),
    .wlo      (wlo),
    .wHiData  (wHiData),
    .whi      (whi)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Stimulus driver: called just after a rising edge; that cycle is cycle 0. Returns the
  // relative cycle of the done pulse (-1 if none within budget) plus observed results.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int doneCyc, output logic [31:0] lo, output logic [31:0] hi,
                        output bit stallOk, output bit wrOk);
    doneCyc  = -1;
    lo       = '0;
    hi       = '0;
    stallOk  = 1'b1;
    wrOk     = 1'b1;
    start    = 1'b1;
    signed_i = sgn;
    dividend = a;
    divisor  = b;
    for (int c = 0; c < 60 && doneCyc < 0; c++) begin
      @(negedge clk);
      if (stall !== (c <= 33)) stallOk = 1'b0;
      if (wlo !== done || whi !== done) wrOk = 1'b0;
      if (done === 1'b1) begin
        doneCyc = c;
        lo      = wLoData;
        hi      = wHiData;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; signed_i = 1'b0; dividend = '0; divisor = '0; cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    nCompared++; if (stall !== 1'b0) begin nMismatched++; $display("FAIL reset_stall: got %b want 0", stall); end
    nCompared++; if (done !== 1'b0) begin nMismatched++; $display("FAIL reset_done: got %b want 0", done); end
    nCompared++; if (wlo !== 1'b0 || whi !== 1'b0) begin nMismatched++; $display("FAIL reset_we: got wlo=%b whi=%b want 0/0", wlo, whi); end
    nCompared++; if (wLoData !== 32'h0) begin nMismatched++; $display("FAIL reset_lo: got %h want 00000000", wLoData); end
    nCompared++; if (wHiData !== 32'h0) begin nMismatched++; $display("FAIL reset_hi: got %h want 00000000", wHiData); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_divu_basic();
    int d; logic [31:0] lo, hi; bit sOk, wOk;
    do_div(1'b0, 32'd100, 32'd7, d, lo, hi, sOk, wOk);
    nCompared++; if (d !== 34) begin nMismatched++; $display("FAIL divu_latency: got %0d want 34", d); end
    nCompared++; if (lo !== 32'd14) begin nMismatched++; $display("FAIL divu_lo: got %0d want 14", lo); end
    nCompared++; if (hi !== 32'd2) begin nMismatched++; $display("FAIL divu_hi: got %0d want 2", hi); end
    nCompared++; if (!sOk) begin nMismatched++; $display("FAIL divu_stall_window: got bad stall want high cycles 0..33 only"); end
    nCompared++; if (!wOk) begin nMismatched++; $display("FAIL divu_we_follow_done: got wlo/whi != done want equal"); end
    @(negedge clk);
    nCompared++; if (done !== 1'b0 || wlo !== 1'b0) begin nMismatched++; $display("FAIL divu_one_pulse: got done=%b wlo=%b want 0/0", done, wlo); end
    nCompared++; if (wLoData !== 32'd14 || wHiData !== 32'd2) begin nMismatched++; $display("FAIL divu_hold: got %0d/%0d want 14/2", wLoData, wHiData); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_signed_and_edges();
    logic        sg [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] va [7] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFB,
                            32'hFFFFFF9C};
    logic [31:0] vb [7] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd7};
    logic [31:0] eq [7] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'h00000001, 32'hFFFFFFF2};
    logic [31:0] er [7] = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd5, 32'hFFFFFFFB, 32'hFFFFFFFE};
    for (int i = 0; i < 7; i++) begin
      int d; logic [31:0] lo, hi; bit sOk, wOk;
      do_div(sg[i], va[i], vb[i], d, lo, hi, sOk, wOk);
      nCompared++; if (d !== 34) begin nMismatched++; $display("FAIL vec%0d_latency: got %0d want 34", i, d); end
      nCompared++; if (lo !== eq[i]) begin nMismatched++; $display("FAIL vec%0d_lo: got %h want %h", i, lo, eq[i]); end
      nCompared++; if (hi !== er[i]) begin nMismatched++; $display("FAIL vec%0d_hi: got %h want %h", i, hi, er[i]); end
      nCompared++; if (!sOk) begin nMismatched++; $display("FAIL vec%0d_stall: got bad stall window want cycles 0..33", i); end
    end
  endtask

  task automatic test_cancel();
    int d; logic [31:0] lo, hi; bit sOk, wOk; bit sawDone;
    sawDone = 1'b0;
    start = 1'b1; signed_i = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) sawDone = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    cancel = 1'b1;
    @(negedge clk);
    nCompared++; if (stall !== 1'b1) begin nMismatched++; $display("FAIL cancel_c10_stall: got %b want 1", stall); end
    @(posedge clk);
    #1;
    cancel = 1'b0;
    @(negedge clk);
    nCompared++; if (stall !== 1'b0) begin nMismatched++; $display("FAIL cancel_c11_stall: got %b want 0", stall); end
    if (done === 1'b1) sawDone = 1'b1;
    nCompared++; if (sawDone) begin nMismatched++; $display("FAIL cancel_no_done: got done pulse want none"); end
    @(posedge clk);
    #1;
    do_div(1'b0, 32'd9, 32'd3, d, lo, hi, sOk, wOk);
    nCompared++; if (12 + d !== 46) begin nMismatched++; $display("FAIL cancel_restart_cycle: got %0d want 46", 12 + d); end
    nCompared++; if (lo !== 32'd3 || hi !== 32'd0) begin nMismatched++; $display("FAIL cancel_restart_res: got %0d/%0d want 3/0", lo, hi); end

    // cancel and start together in IDLE: cancel wins
    start = 1'b1; cancel = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    nCompared++; if (stall !== 1'b0) begin nMismatched++; $display("FAIL cancel_start_stall: got %b want 0", stall); end
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    nCompared++; if (stall !== 1'b0) begin nMismatched++; $display("FAIL cancel_start_idle: got %b want 0", stall); end
    @(posedge clk);
    #1;

    // cancel during DONE suppresses the write pulse
    start = 1'b1; dividend = 32'd77; divisor = 32'd7;
    for (int c = 0; c < 34; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    cancel = 1'b1;
    @(negedge clk);
    nCompared++; if (done !== 1'b0 || wlo !== 1'b0 || whi !== 1'b0) begin nMismatched++; $display("FAIL cancel_done: got done=%b wlo=%b whi=%b want 0", done, wlo, whi); end
    @(posedge clk);
    #1;
    cancel = 1'b0;
    @(negedge clk);
    nCompared++; if (done !== 1'b0) begin nMismatched++; $display("FAIL cancel_done_after: got %b want 0", done); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    start = 1'b1; signed_i = 1'b0; dividend = 32'd500; divisor = 32'd9;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    nCompared++; if (stall !== 1'b0 || done !== 1'b0) begin nMismatched++; $display("FAIL rstmid_ctrl: got stall=%b done=%b want 0/0", stall, done); end
    nCompared++; if (wLoData !== 32'h0 || wHiData !== 32'h0) begin nMismatched++; $display("FAIL rstmid_data: got %h/%h want 0/0", wLoData, wHiData); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin nCompared++; nMismatched++; $display("FAIL rstmid_no_write: got done at +%0d want none", c); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_start_ignored();
    int d; logic [31:0] lo, hi;
    d = -1; lo = '0; hi = '0;
    start = 1'b1; signed_i = 1'b0; dividend = 32'd9; divisor = 32'd3;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      if (done === 1'b1 && d < 0) begin d = c; lo = wLoData; hi = wHiData; end
      @(posedge clk);
      #1;
      dividend = 32'd100; divisor = 32'd7;
    end
    start = 1'b0;
    nCompared++; if (d !== 34) begin nMismatched++; $display("FAIL held_start_latency: got %0d want 34", d); end
    nCompared++; if (lo !== 32'd3 || hi !== 32'd0) begin nMismatched++; $display("FAIL held_start_res: got %0d/%0d want 3/0", lo, hi); end
    @(negedge clk);
    nCompared++; if (stall !== 1'b0) begin nMismatched++; $display("FAIL held_start_idle: got %b want 0", stall); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int d1, d2; logic [31:0] lo1, hi1, lo2, hi2; bit s1, s2, w1, w2;
    do_div(1'b0, 32'd9, 32'd3, d1, lo1, hi1, s1, w1);
    do_div(1'b0, 32'd10, 32'd4, d2, lo2, hi2, s2, w2);
    nCompared++; if (d1 !== 34) begin nMismatched++; $display("FAIL b2b_first_cycle: got %0d want 34", d1); end
    nCompared++; if (lo1 !== 32'd3 || hi1 !== 32'd0) begin nMismatched++; $display("FAIL b2b_first_res: got %0d/%0d want 3/0", lo1, hi1); end
    nCompared++; if (d1 + 1 + d2 !== 69) begin nMismatched++; $display("FAIL b2b_second_cycle: got %0d want 69", d1 + 1 + d2); end
    nCompared++; if (lo2 !== 32'd2 || hi2 !== 32'd2) begin nMismatched++; $display("FAIL b2b_second_res: got %0d/%0d want 2/2", lo2, hi2); end
    nCompared++; if (!s2) begin nMismatched++; $display("FAIL b2b_second_stall: got bad stall window want cycles 0..33"); end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed_and_edges();
    test_cancel();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
